// File: rtl/csr_issue.sv
// In-order CSR issue controller: queues dispatched CSR micro-ops and releases
// the oldest one only when it is the commit head, keeping at most one op in flight.

`ifndef CSR_EXEPARAM_DW
`define CSR_EXEPARAM_DW 32
`endif

module csr_issue #(
  parameter int DW = `CSR_EXEPARAM_DW,
  parameter int DP = 4,
  parameter int TW = 6
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     flush,
  input  logic                     csr_issue_vaild,
  input  logic [DW-1:0]            csr_issue_param,
  input  logic [TW-1:0]            csr_issue_tag,
  output logic                     csr_issue_ready,
  input  logic                     commit_head_vaild,
  input  logic [TW-1:0]            commit_head_tag,
  output logic                     csr_exeparam_vaild,
  output logic [DW-1:0]            csr_exeparam,
  input  logic                     csr_writeback_vaild,
  output logic                     csr_busy,
  output logic [$clog2(DP):0]      csr_fifo_cnt
);

  localparam int AW = $clog2(DP);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic [DW-1:0] param_mem [DP];
  logic [TW-1:0] tag_mem   [DP];
  logic          push;
  logic          pop;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even when the head is being popped in the same cycle.
  assign csr_issue_ready = (cnt_reg != CW'(DP));
  assign push            = csr_issue_vaild & csr_issue_ready & ~flush;
  assign pop             = (state_reg == IDLE) & (cnt_reg != '0) & commit_head_vaild
                         & (tag_mem[rd_ptr_reg] == commit_head_tag) & ~flush;

  assign csr_busy     = (state_reg != IDLE);
  assign csr_fifo_cnt = cnt_reg;

  always_ff @(posedge CLK) begin
    if (push) begin
      param_mem[wr_ptr_reg] <= csr_issue_param;
      tag_mem[wr_ptr_reg]   <= csr_issue_tag;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_reg          <= IDLE;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      cnt_reg            <= '0;
      csr_exeparam_vaild <= 1'b0;
      csr_exeparam       <= '0;
    end else if (flush) begin
      // csr_exeparam keeps its last value; only the strobe is cancelled.
      state_reg          <= IDLE;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      cnt_reg            <= '0;
      csr_exeparam_vaild <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase

      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg          <= ISSUE;
            csr_exeparam_vaild <= 1'b1;
            csr_exeparam       <= param_mem[rd_ptr_reg];
          end
        end
        ISSUE: begin
          state_reg          <= WAIT;
          csr_exeparam_vaild <= 1'b0;
        end
        WAIT: begin
          if (csr_writeback_vaild) state_reg <= IDLE;
        end
        default: begin
          state_reg          <= IDLE;
          csr_exeparam_vaild <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_issue.sv
// Randomized bench for csr_issue: an abstract queue model predicts every strobe,
// and a monitor checks each strobe's param and cycle against the expectation queue.

module tb_csr_issue;

  localparam int DW = 16;
  localparam int DP = 4;
  localparam int TW = 6;
  localparam int CW = $clog2(DP) + 1;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b1;
  logic          flush = 1'b0;
  logic          csr_issue_vaild = 1'b0;
  logic [DW-1:0] csr_issue_param = '0;
  logic [TW-1:0] csr_issue_tag = '0;
  logic          csr_issue_ready;
  logic          commit_head_vaild = 1'b0;
  logic [TW-1:0] commit_head_tag = '0;
  logic          csr_exeparam_vaild;
  logic [DW-1:0] csr_exeparam;
  logic          csr_writeback_vaild = 1'b0;
  logic          csr_busy;
  logic [CW-1:0] csr_fifo_cnt;

  csr_issue #(.DW(DW), .DP(DP), .TW(TW)) dut (
    .CLK                 (CLK),
    .RSTn                (RSTn),
    .flush               (flush),
    .csr_issue_vaild     (csr_issue_vaild),
    .csr_issue_param     (csr_issue_param),
    .csr_issue_tag       (csr_issue_tag),
    .csr_issue_ready     (csr_issue_ready),
    .commit_head_vaild   (commit_head_vaild),
    .commit_head_tag     (commit_head_tag),
    .csr_exeparam_vaild  (csr_exeparam_vaild),
    .csr_exeparam        (csr_exeparam),
    .csr_writeback_vaild (csr_writeback_vaild),
    .csr_busy            (csr_busy),
    .csr_fifo_cnt        (csr_fifo_cnt)
  );

  always #5 CLK = ~CLK;

  longint cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] p;
    logic [TW-1:0] t;
  } ent_t;

  typedef struct {
    logic [DW-1:0] p;
    longint        c;
  } exp_t;

  // Reference model: queue contents plus "op strobing now" / "op awaiting writeback".
  ent_t          mq[$];
  exp_t          expq[$];
  bit            m_strobe = 0;
  bit            m_wait = 0;
  logic [DW-1:0] m_param = '0;
  bit            m_param_known = 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [TW-1:0] head_tag();
    if (mq.size() != 0) return mq[0].t;
    return '0;
  endfunction

  function automatic bit head_exists();
    return mq.size() != 0;
  endfunction

  // Called at a falling edge: checks the outputs against the model, drives the
  // next cycle's inputs, advances the model past the coming rising edge.
  task automatic step(input bit v, input logic [DW-1:0] p, input logic [TW-1:0] t,
                      input bit hv, input logic [TW-1:0] ht, input bit wb, input bit fl);
    bit   iss;
    bit   can_push;
    bit   new_wait;
    ent_t e;
    chk("fifo_cnt", 64'(csr_fifo_cnt), 64'(mq.size()));
    chk("issue_ready", 64'(csr_issue_ready), 64'(mq.size() != DP));
    chk("busy", 64'(csr_busy), 64'(m_strobe || m_wait));
    if (m_param_known) chk("exeparam_hold", 64'(csr_exeparam), 64'(m_param));

    csr_issue_vaild     = v;
    csr_issue_param     = p;
    csr_issue_tag       = t;
    commit_head_vaild   = hv;
    commit_head_tag     = ht;
    csr_writeback_vaild = wb;
    flush               = fl;

    if (fl) begin
      mq.delete();
      m_strobe      = 0;
      m_wait        = 0;
      m_param_known = 0;
    end else begin
      can_push = v && (mq.size() != DP);
      iss      = !m_strobe && !m_wait && (mq.size() != 0) && hv && (mq[0].t == ht);
      new_wait = m_strobe || (m_wait && !wb);
      if (iss) begin
        e = mq.pop_front();
        m_param       = e.p;
        m_param_known = 1;
        expq.push_back('{p: e.p, c: cyc + 1});
      end
      if (can_push) mq.push_back('{p: p, t: t});
      m_wait   = new_wait;
      m_strobe = iss;
    end
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic reset_check();
    #2 RSTn = 1'b0;
    #1;
    chk("rst_vaild", 64'(csr_exeparam_vaild), 64'd0);
    chk("rst_param", 64'(csr_exeparam), 64'd0);
    chk("rst_busy", 64'(csr_busy), 64'd0);
    chk("rst_cnt", 64'(csr_fifo_cnt), 64'd0);
    chk("rst_ready", 64'(csr_issue_ready), 64'd1);
    mq.delete();
    expq.delete();
    m_strobe = 0;
    m_wait = 0;
    m_param = '0;
    m_param_known = 1;
    csr_issue_vaild = 0;
    commit_head_vaild = 0;
    csr_writeback_vaild = 0;
    flush = 0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
  endtask

  // Monitor: every strobe must match the oldest expectation, on its cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (csr_exeparam_vaild) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got param %0h expected no strobe (cycle %0d)",
                   csr_exeparam, cyc);
        end else begin
          e = expq.pop_front();
          chk("strobe_param", 64'(csr_exeparam), 64'(e.p));
          chk("strobe_cycle", 64'(cyc), 64'(e.c));
        end
      end else if (expq.size() != 0 && expq[0].c <= cyc) begin
        e = expq.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_strobe: got none expected param %0h at cycle %0d", e.p, e.c);
      end
    end
  end

  initial begin
    @(negedge CLK);
    reset_check();

    // Mismatched head tag: entry waits indefinitely.
    step(1, DW'(16'h1111), TW'(5), 1, TW'(3), 0, 0);
    for (int i = 0; i < 20; i++) step(0, '0, '0, 1, TW'(3), 0, 0);

    // Single issue with 1-cycle writeback.
    step(0, '0, '0, 0, '0, 0, 1);
    step(1, DW'(16'h00A5), TW'(3), 1, TW'(3), 0, 0);
    step(0, '0, '0, 1, TW'(3), 0, 0);
    step(0, '0, '0, 0, '0, 0, 0);
    step(0, '0, '0, 0, '0, 1, 0);
    idle(3);

    // Fill to full, refused fifth push, then drain entry 0.
    step(0, '0, '0, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, DW'(16'h0100 + i), TW'(10 + i), 1, '0, 0, 0);
    step(1, DW'(16'h01FF), TW'(14), 1, '0, 0, 0);
    step(0, '0, '0, 1, TW'(10), 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, '0, 0, '0, 1, 0);

    // Ordered stream; commit head follows the queue head, writeback every cycle.
    step(0, '0, '0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, DW'(16'h0700 + i), TW'(7 + i), 0, '0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, '0, '0, head_exists(), head_tag(), 1, 0);

    // Writeback stall with a matching head waiting behind it.
    step(0, '0, '0, 0, '0, 0, 1);
    step(1, DW'(16'h2020), TW'(20), 0, '0, 0, 0);
    step(1, DW'(16'h2121), TW'(21), 1, TW'(20), 0, 0);
    for (int i = 0; i < 6; i++) step(0, '0, '0, 1, TW'(21), 0, 0);
    for (int i = 0; i < 5; i++) step(0, '0, '0, 1, TW'(21), 1, 0);

    // Flush while the strobe is out with 2 entries queued; push in the flush is dropped.
    step(0, '0, '0, 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, DW'(16'h3000 + i), TW'(30 + i), 0, '0, 0, 0);
    step(0, '0, '0, 1, TW'(30), 0, 0);
    chk("in_issue_before_flush", 64'(csr_exeparam_vaild), 64'd1);
    step(1, DW'(16'h0777), TW'(40), 1, TW'(31), 0, 1);
    step(0, '0, '0, 1, TW'(31), 1, 0);
    idle(3);

    // Randomized traffic, with an asynchronous reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      bit            v;
      bit            hv;
      bit            wb;
      bit            fl;
      logic [TW-1:0] ht;
      v  = ($urandom % 2) == 1;
      hv = ($urandom % 4) != 0;
      ht = (head_exists() && ($urandom % 2) == 1) ? head_tag() : TW'($urandom_range(0, 7));
      wb = m_wait ? (($urandom % 2) == 1) : (($urandom % 8) == 0);
      fl = ($urandom % 50) == 0;
      step(v, DW'($urandom), TW'($urandom_range(0, 7)), hv, ht, wb, fl);
      if (n == 700) reset_check();
    end

    idle(4);
    chk("pending_strobes", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
